// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared Mini-MIPS types and immediate-extension mode constants
package mips_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_SIGN   = 2'b00;
  localparam ext_mode_t EXT_ZERO   = 2'b01;
  localparam ext_mode_t EXT_UPPER  = 2'b10;
  localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational immediate extension (sign, zero, upper, branch)
module imm_ext_core
  import mips_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] data
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] branch;

  assign sext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zext   = {{(OUT_W-IN_W){1'b0}}, imm};
  assign upper  = {imm, {(OUT_W-IN_W){1'b0}}};
  // Bits shifted past the MSB are simply lost; zeros enter at the LSB.
  assign branch = sext << SHAMT;

  always_comb begin
    data = sext;
    case (mode)
      EXT_SIGN:   data = sext;
      EXT_ZERO:   data = zext;
      EXT_UPPER:  data = upper;
      EXT_BRANCH: data = branch;
      default:    data = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate extender behind a two-entry valid/ready skid buffer
module imm_extend_pipe
  import mips_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (IN_W < 2 || IN_W >= OUT_W) begin : g_bad_in_w
    $fatal(1, "imm_extend_pipe: IN_W must satisfy 2 <= IN_W < OUT_W");
  end
  if (SHAMT < 0 || IN_W + SHAMT > OUT_W) begin : g_bad_shamt
    $fatal(1, "imm_extend_pipe: SHAMT must satisfy 0 <= SHAMT and IN_W+SHAMT <= OUT_W");
  end

  logic [OUT_W-1:0] ext_data;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHAMT (SHAMT)
  ) u_core (
    .imm  (in_imm),
    .mode (ext_mode_t'(in_mode)),
    .data (ext_data)
  );

  logic             main_valid;
  logic [OUT_W-1:0] main_data;
  logic [TAG_W-1:0] main_tag;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;

  logic in_fire;
  logic drain;

  // in_ready looks only at registered skid state plus reset/flush, never at out_ready.
  assign in_ready  = !reset && !flush && !skid_valid;
  assign in_fire   = in_valid && in_ready;
  assign drain     = main_valid && out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_tag   = main_tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_tag   <= skid_tag;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_fire;
        if (in_fire) begin
          main_data <= ext_data;
          main_tag  <= in_tag;
        end
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= ext_data;
      skid_tag   <= in_tag;
    end
  end

endmodule
